// File: rtl/run_monitor.sv
// Run controller and write-back monitor for the MIPS skeleton core: sequences core reset,
// bounds a run by cycle budget or halt write, and traces/checksums every register write.
module run_monitor #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned RESET_CYCLES   = 2,
    parameter int unsigned MAX_CYCLES     = 200,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TRACE_DEPTH    = 16,
    parameter int unsigned HALT_REG       = 30
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic                      core_reset,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_reg,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      trace_pop,
    output logic                      trace_valid,
    output logic [REG_ADDR_WIDTH-1:0] trace_reg,
    output logic [DATA_WIDTH-1:0]     trace_data,
    output logic                      trace_overflow,
    output logic [CNT_WIDTH-1:0]      cycle_count,
    output logic [DATA_WIDTH-1:0]     checksum,
    output logic [DATA_WIDTH-1:0]     halt_value,
    output logic                      running,
    output logic                      done,
    output logic                      timeout
);

    localparam int unsigned HoldW  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned PtrW   = $clog2(TRACE_DEPTH);
    localparam int unsigned CountW = PtrW + 1;
    localparam int unsigned EntryW = REG_ADDR_WIDTH + DATA_WIDTH;

    localparam logic [HoldW-1:0]          HoldLast  = HoldW'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]      LastCycle = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam logic [CountW-1:0]         FullCount = CountW'(TRACE_DEPTH);
    localparam logic [REG_ADDR_WIDTH-1:0] HaltIdx   = REG_ADDR_WIDTH'(HALT_REG);

    typedef enum logic [1:0] {StIdle, StHold, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
    logic [DATA_WIDTH-1:0] halt_value_q, halt_value_d;
    logic                  timeout_q, timeout_d;
    logic                  overflow_q, overflow_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0]     count_q, count_d;
    logic [EntryW-1:0]     mem [TRACE_DEPTH];

    logic clear, record, halt_hit, pop_ok, full, push_ok;

    always_comb begin
        clear    = start && (state_q == StIdle || state_q == StDone);
        record   = (state_q == StRun) && wb_en && (wb_reg != '0);
        halt_hit = record && (wb_reg == HaltIdx);
        pop_ok   = trace_pop && (count_q != '0);
        full     = (count_q == FullCount);
        // A full FIFO still accepts a push when the head is popped in the same cycle.
        push_ok  = record && (!full || pop_ok);
    end

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cycle_count_d = cycle_count_q;
        checksum_d    = checksum_q;
        halt_value_d  = halt_value_q;
        timeout_d     = timeout_q;
        overflow_d    = overflow_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StHold;
                    hold_cnt_d = '0;
                end
            end
            StHold: begin
                if (hold_cnt_q == HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StRun: begin
                // Halt takes priority over the budget; the final RUN cycle is not counted.
                if (halt_hit) begin
                    state_d      = StDone;
                    halt_value_d = wb_data;
                end else if (cycle_count_q == LastCycle) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end else begin
                    cycle_count_d = cycle_count_q + 1'b1;
                end
                if (record) begin
                    checksum_d = {checksum_q[DATA_WIDTH-2:0], checksum_q[DATA_WIDTH-1]}
                                 ^ wb_data ^ DATA_WIDTH'(wb_reg);
                end
            end
            default: state_d = StIdle;
        endcase

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        if (record && !push_ok) begin
            overflow_d = 1'b1;
        end

        if (clear) begin
            cycle_count_d = '0;
            checksum_d    = '0;
            halt_value_d  = '0;
            timeout_d     = 1'b0;
            overflow_d    = 1'b0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            hold_cnt_q    <= '0;
            cycle_count_q <= '0;
            checksum_q    <= '0;
            halt_value_q  <= '0;
            timeout_q     <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cycle_count_q <= cycle_count_d;
            checksum_q    <= checksum_d;
            halt_value_q  <= halt_value_d;
            timeout_q     <= timeout_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= {wb_reg, wb_data};
        end
    end

    always_comb begin
        core_reset     = (state_q != StRun);
        running        = (state_q == StRun);
        done           = (state_q == StDone);
        trace_valid    = (count_q != '0);
        trace_reg      = mem[rd_ptr_q][DATA_WIDTH +: REG_ADDR_WIDTH];
        trace_data     = mem[rd_ptr_q][DATA_WIDTH-1:0];
        trace_overflow = overflow_q;
        cycle_count    = cycle_count_q;
        checksum       = checksum_q;
        halt_value     = halt_value_q;
        timeout        = timeout_q;
    end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: reset sequencing, halt, timeout, coincidence,
// trace FIFO overflow, mid-run reset and restart clearing.
module tb_run_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        core_reset;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        trace_pop;
    logic        trace_valid;
    logic [4:0]  trace_reg;
    logic [31:0] trace_data;
    logic        trace_overflow;
    logic [15:0] cycle_count;
    logic [31:0] checksum;
    logic [31:0] halt_value;
    logic        running;
    logic        done;
    logic        timeout;

    int tests  = 0;
    int failed = 0;

    run_monitor dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .core_reset     (core_reset),
        .wb_en          (wb_en),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .trace_pop      (trace_pop),
        .trace_valid    (trace_valid),
        .trace_reg      (trace_reg),
        .trace_data     (trace_data),
        .trace_overflow (trace_overflow),
        .cycle_count    (cycle_count),
        .checksum       (checksum),
        .halt_value     (halt_value),
        .running        (running),
        .done           (done),
        .timeout        (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Pulse start and wait out the two HOLD cycles; returns on the first RUN cycle.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
    endtask

    function automatic logic [31:0] mix(input logic [31:0] c, input logic [4:0] r,
                                        input logic [31:0] d);
        return {c[30:0], c[31]} ^ d ^ {27'd0, r};
    endfunction

    logic [31:0] model_sum;

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        wb_en     = 1'b0;
        wb_reg    = '0;
        wb_data   = '0;
        trace_pop = 1'b0;
        step();
        step();
        check("rst_core_reset", core_reset, 1);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_trace_valid", trace_valid, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_checksum", checksum, 0);

        // Reset sequencing: exactly two HOLD cycles with core_reset high.
        reset = 1'b1;
        step();
        check("idle_core_reset", core_reset, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("hold1_core_reset", core_reset, 1);
        check("hold1_running", running, 0);
        step();
        check("hold2_core_reset", core_reset, 1);
        check("hold2_running", running, 0);
        step();
        check("run0_core_reset", core_reset, 0);
        check("run0_running", running, 1);
        check("run0_cycle_count", cycle_count, 0);

        // Halt run: r5, r0 (ignored), r30 halts.
        wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'h11;
        step();
        check("push_head_valid", trace_valid, 1);
        wb_reg = 5'd0; wb_data = 32'hFF;
        step();
        wb_reg = 5'd30; wb_data = 32'h600D;
        step();
        wb_en = 1'b0;
        check("halt_done", done, 1);
        check("halt_running", running, 0);
        check("halt_timeout", timeout, 0);
        check("halt_core_reset", core_reset, 1);
        check("halt_value", halt_value, 32'h600D);
        check("halt_checksum", checksum, 32'h603B);
        check("halt_cycle_count", cycle_count, 2);
        check("trace0_reg", trace_reg, 5);
        check("trace0_data", trace_data, 32'h11);
        trace_pop = 1'b1;
        step();
        check("trace1_reg", trace_reg, 30);
        check("trace1_data", trace_data, 32'h600D);
        step();
        check("trace_empty", trace_valid, 0);
        step();
        trace_pop = 1'b0;
        check("pop_empty_ignored", trace_valid, 0);
        check("done_frozen_count", cycle_count, 2);

        // Restart from DONE clears everything, then let the budget expire.
        do_start();
        check("restart_checksum", checksum, 0);
        check("restart_halt_value", halt_value, 0);
        check("restart_timeout", timeout, 0);
        check("restart_cycle_count", cycle_count, 0);
        check("restart_running", running, 1);
        for (int i = 0; i < 199; i++) step();
        check("to_last_count", cycle_count, 199);
        check("to_last_running", running, 1);
        step();
        check("to_done", done, 1);
        check("to_timeout", timeout, 1);
        check("to_cycle_count", cycle_count, 199);
        check("to_core_reset", core_reset, 1);

        // Halt on the final budget cycle: halt wins.
        do_start();
        check("co_timeout_cleared", timeout, 0);
        for (int i = 0; i < 199; i++) step();
        wb_en = 1'b1; wb_reg = 5'd30; wb_data = 32'h1;
        step();
        wb_en = 1'b0;
        check("co_done", done, 1);
        check("co_timeout", timeout, 0);
        check("co_halt_value", halt_value, 1);
        check("co_cycle_count", cycle_count, 199);

        // Overflow: 17 writes, no pops; the 17th is dropped but checksummed.
        do_start();
        check("ov_fifo_cleared", trace_valid, 0);
        model_sum = '0;
        for (int i = 0; i < 17; i++) begin
            wb_en = 1'b1; wb_reg = 5'(i + 1); wb_data = 32'h100 + 32'(i);
            model_sum = mix(model_sum, 5'(i + 1), 32'h100 + 32'(i));
            step();
        end
        wb_en = 1'b0;
        check("ov_flag", trace_overflow, 1);
        check("ov_checksum", checksum, model_sum);
        check("ov_running", running, 1);
        trace_pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ov_reg%0d", i), trace_reg, 32'(i + 1));
            check($sformatf("ov_data%0d", i), trace_data, 32'h100 + 32'(i));
            step();
        end
        trace_pop = 1'b0;
        check("ov_drained", trace_valid, 0);
        check("ov_flag_sticky", trace_overflow, 1);

        // Mid-run reset: asynchronous abort to IDLE.
        reset = 1'b0;
        #1;
        check("mr_core_reset", core_reset, 1);
        check("mr_running", running, 0);
        check("mr_overflow", trace_overflow, 0);
        check("mr_checksum", checksum, 0);
        step();
        reset = 1'b1;
        step();
        do_start();
        for (int i = 0; i < 50; i++) step();
        check("mr50_count", cycle_count, 50);
        reset = 1'b0;
        #1;
        check("mr50_core_reset", core_reset, 1);
        check("mr50_running", running, 0);
        check("mr50_count_zero", cycle_count, 0);
        check("mr50_done", done, 0);
        step();
        reset = 1'b1;
        step();

        // Overflow variant: pop on the 17th push keeps every write.
        do_start();
        for (int i = 0; i < 17; i++) begin
            wb_en = 1'b1; wb_reg = 5'(i + 1); wb_data = 32'h200 + 32'(i);
            trace_pop = (i == 16);
            step();
        end
        wb_en = 1'b0;
        trace_pop = 1'b0;
        check("nov_flag", trace_overflow, 0);
        trace_pop = 1'b1;
        for (int i = 1; i < 17; i++) begin
            check($sformatf("nov_reg%0d", i), trace_reg, 32'(i + 1));
            check($sformatf("nov_data%0d", i), trace_data, 32'h200 + 32'(i));
            step();
        end
        trace_pop = 1'b0;
        check("nov_drained", trace_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
